// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter_if
// Purpose : Bundles the two cache request ports, their grant/completion
//           responses and the single-port data memory connection of the
//           mem_port_arbiter.
// Ports   : req0/req1, we0/we1, addr0/addr1, wdata0/wdata1  - requester side
//           gnt0/gnt1, done0/done1, rdata0/rdata1, busy        - responses
//           mem_address, mem_wdata, mem_load_control,
//           mem_store_control                                  - to memory
//           mem_rdata                                          - from memory
// Modports: slave  - the arbiter
//           master - the environment (caches plus data memory)
// Revision: 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              busy;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_load_control;
  logic              mem_store_control;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, done0, done1, rdata0, rdata1, busy,
           mem_address, mem_wdata, mem_load_control, mem_store_control
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, done0, done1, rdata0, rdata1, busy,
           mem_address, mem_wdata, mem_load_control, mem_store_control
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter
// Purpose : Shares one single-port data memory between two cache ports.
//           Each transaction is IDLE -> ACCESS -> RESP: the winning request
//           is latched in IDLE, the memory enable is driven for exactly one
//           cycle in ACCESS, and done plus the registered load data are
//           presented in RESP. Ties go to the port not served most recently.
// Ports   : clk     - single clock, rising edge
//           n_reset - synchronous active-low reset
//           bus     - mem_port_arbiter_if.slave (requests, responses, memory)
// Revision: 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                n_reset,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              owner;
  logic              last_served;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              winner;
  logic              start;

  // Next state, arbitration and all decoded outputs.
  always_comb begin
    state_next            = state;
    // Single requester wins outright; on a tie the port not served last wins.
    winner                = (bus.req0 && bus.req1) ? ~last_served : bus.req1;
    start                 = 1'b0;
    bus.gnt0              = 1'b0;
    bus.gnt1              = 1'b0;
    bus.done0             = 1'b0;
    bus.done1             = 1'b0;
    bus.busy              = 1'b0;
    bus.mem_address       = '0;
    bus.mem_wdata         = '0;
    bus.mem_load_control  = 1'b0;
    bus.mem_store_control = 1'b0;

    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          start      = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        state_next            = RESP;
        bus.busy              = 1'b1;
        bus.gnt0              = ~owner;
        bus.gnt1              = owner;
        bus.mem_address       = lat_addr;
        bus.mem_wdata         = lat_wdata;
        bus.mem_store_control = lat_we;
        bus.mem_load_control  = ~lat_we;
      end
      RESP: begin
        state_next = IDLE;
        bus.busy   = 1'b1;
        bus.gnt0   = ~owner;
        bus.gnt1   = owner;
        bus.done0  = ~owner;
        bus.done1  = owner;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state       <= IDLE;
      last_served <= 1'b1;   // port 0 wins the first tie after reset
      owner       <= 1'b0;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        owner       <= winner;
        last_served <= winner;
        lat_we      <= winner ? bus.we1    : bus.we0;
        lat_addr    <= winner ? bus.addr1  : bus.addr0;
        lat_wdata   <= winner ? bus.wdata1 : bus.wdata0;
      end
      // Load data is captured on the edge leaving ACCESS, into the owner only.
      if (state == ACCESS && !lat_we) begin
        if (owner) begin
          rdata1_q <= bus.mem_rdata;
        end else begin
          rdata0_q <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.rdata0 = rdata0_q;
  assign bus.rdata1 = rdata1_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_port_arbiter
// Purpose : Self-checking bench for mem_port_arbiter. A table of single-port
//           transactions plus hand-written sequences for contention, late
//           requests and reset in the middle of a store. Expected accesses
//           are queued when driven and compared when the DUT drives the
//           memory and when it signals done.
// Revision: 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus.slave)
  );

  // Data memory: synchronous write, asynchronous read, plus a preload path.
  logic [DATA_W-1:0] mem [64];
  logic              pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [DATA_W-1:0] pre_data = '0;
  always @(posedge clk) begin
    if (bus.mem_store_control) mem[bus.mem_address] <= bus.mem_wdata;
    else if (pre_we)           mem[pre_addr] <= pre_data;
  end
  assign bus.mem_rdata = mem[bus.mem_address];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic              port;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;   // expected load result (ignored for stores)
  } txn_t;

  txn_t        sbq[$];
  txn_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_store = 0;
  int          acc_cyc = 0;
  logic [31:0] exp_rd0 = '0;
  logic [31:0] exp_rd1 = '0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("gnt_exclusive", {31'b0, bus.gnt0 & bus.gnt1}, 32'd0);
      if (bus.mem_load_control || bus.mem_store_control) begin
        acc_cyc = cyc;
        if (bus.mem_store_control) n_store++;
        if (sbq.size() == 0) begin
          chk("unexpected_access", 32'd1, 32'd0);
        end else begin
          mon_e = sbq[0];
          chk("acc_gnt_owner", {31'b0, mon_e.port ? bus.gnt1 : bus.gnt0}, 32'd1);
          chk("acc_gnt_other", {31'b0, mon_e.port ? bus.gnt0 : bus.gnt1}, 32'd0);
          chk("acc_addr", {26'b0, bus.mem_address}, {26'b0, mon_e.addr});
          chk("acc_wdata", bus.mem_wdata, mon_e.wdata);
          chk("acc_store_en", {31'b0, bus.mem_store_control}, {31'b0, mon_e.we});
          chk("acc_load_en", {31'b0, bus.mem_load_control}, {31'b0, ~mon_e.we});
        end
      end else begin
        chk("idle_mem_addr", {26'b0, bus.mem_address}, 32'd0);
        chk("idle_mem_wdata", bus.mem_wdata, 32'd0);
      end
      if (bus.done0 || bus.done1) begin
        chk("done_exclusive", {31'b0, bus.done0 & bus.done1}, 32'd0);
        if (sbq.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          chk("done_port", {31'b0, bus.done1}, {31'b0, mon_e.port});
          chk("done_gnt", {31'b0, mon_e.port ? bus.gnt1 : bus.gnt0}, 32'd1);
          if (!mon_e.we) begin
            if (mon_e.port) exp_rd1 = mon_e.rdata;
            else            exp_rd0 = mon_e.rdata;
          end
          chk("rdata0", bus.rdata0, exp_rd0);
          chk("rdata1", bus.rdata1, exp_rd1);
        end
      end
    end
  end

  task automatic set_port(input txn_t t);
    if (t.port) begin
      bus.req1 = 1'b1; bus.we1 = t.we; bus.addr1 = t.addr; bus.wdata1 = t.wdata;
    end else begin
      bus.req0 = 1'b1; bus.we0 = t.we; bus.addr0 = t.addr; bus.wdata0 = t.wdata;
    end
  endtask

  task automatic drop(input logic p);
    if (p) bus.req1 = 1'b0;
    else   bus.req0 = 1'b0;
  endtask

  task automatic wait_done(input logic p, output int at);
    at = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (p ? bus.done1 : bus.done0) begin
        at = cyc;
        return;
      end
    end
    chk("timeout_done", 32'd1, 32'd0);
  endtask

  task automatic wait_any_done(output int at, output logic who);
    at = -1;
    who = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done0 || bus.done1) begin
        at = cyc;
        who = bus.done1;
        return;
      end
    end
    chk("timeout_any_done", 32'd1, 32'd0);
  endtask

  task automatic run_txn(input txn_t t);
    int t0;
    int d;
    @(negedge clk);
    set_port(t);
    sbq.push_back(t);
    t0 = cyc;
    wait_done(t.port, d);
    chk("latency_enable", acc_cyc - t0, 32'd1);
    chk("latency_done", d - t0, 32'd2);
    drop(t.port);
    @(negedge clk);
    chk("idle_after_txn", {31'b0, bus.busy}, 32'd0);
    chk("done_one_cycle", {31'b0, t.port ? bus.done1 : bus.done0}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_reset = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    sbq.delete();
    exp_rd0 = '0;
    exp_rd1 = '0;
  endtask

  txn_t tbl[7];

  initial begin
    int   d0;
    int   d1;
    int   prev;
    logic who;
    txn_t a;
    txn_t b;

    tbl[0] = '{1'b0, 1'b0, 6'd5,  32'h0000_1111, 32'hDEAD_BEEF};
    tbl[1] = '{1'b1, 1'b1, 6'h3F, 32'h1234_5678, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 6'h3F, 32'h0000_2222, 32'h1234_5678};
    tbl[3] = '{1'b0, 1'b1, 6'd0,  32'hCAFE_F00D, 32'h0};
    tbl[4] = '{1'b0, 1'b0, 6'd0,  32'h0,         32'hCAFE_F00D};
    tbl[5] = '{1'b1, 1'b0, 6'd5,  32'h0000_3333, 32'hDEAD_BEEF};
    tbl[6] = '{1'b0, 1'b0, 6'h3F, 32'h0,         32'h1234_5678};

    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;

    // Reset and preload memory word 5.
    n_reset = 1'b0;
    repeat (3) @(negedge clk);
    pre_we = 1'b1; pre_addr = 6'd5; pre_data = 32'hDEAD_BEEF;
    @(negedge clk);
    pre_we = 1'b0;
    chk("rst_gnt0", {31'b0, bus.gnt0}, 32'd0);
    chk("rst_gnt1", {31'b0, bus.gnt1}, 32'd0);
    chk("rst_done0", {31'b0, bus.done0}, 32'd0);
    chk("rst_done1", {31'b0, bus.done1}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_load_en", {31'b0, bus.mem_load_control}, 32'd0);
    chk("rst_store_en", {31'b0, bus.mem_store_control}, 32'd0);
    chk("rst_rdata0", bus.rdata0, 32'd0);
    chk("rst_rdata1", bus.rdata1, 32'd0);
    chk("rst_mem_addr", {26'b0, bus.mem_address}, 32'd0);
    n_reset = 1'b1;
    mon_en = 1'b1;

    // Table of single-port transactions.
    for (int i = 0; i < 7; i++) run_txn(tbl[i]);
    chk("store_pulse_count", n_store, 32'd2);

    // Simultaneous held requests after reset: owners alternate 0,1,0,1.
    do_reset();
    @(negedge clk);
    a = '{1'b0, 1'b0, 6'd5,  32'h0, 32'hDEAD_BEEF};
    b = '{1'b1, 1'b0, 6'h3F, 32'h0, 32'h1234_5678};
    set_port(a);
    set_port(b);
    sbq.push_back(a); sbq.push_back(b); sbq.push_back(a); sbq.push_back(b);
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_any_done(d0, who);
      chk("tie_owner", {31'b0, who}, k % 2);
      if (k > 0) chk("tie_spacing", d0 - prev, 32'd3);
      prev = d0;
    end
    drop(1'b0);
    drop(1'b1);
    @(negedge clk);
    chk("tie_idle_after", {31'b0, bus.busy}, 32'd0);

    // Late request: req1 raised during core 0's ACCESS.
    a = '{1'b0, 1'b0, 6'd0, 32'h0, 32'hCAFE_F00D};
    b = '{1'b1, 1'b0, 6'd5, 32'h0, 32'hDEAD_BEEF};
    @(negedge clk);
    set_port(a);
    sbq.push_back(a);
    @(negedge clk);
    chk("late_p0_access", {31'b0, bus.mem_load_control & bus.gnt0}, 32'd1);
    set_port(b);
    sbq.push_back(b);
    wait_done(1'b0, d0);
    drop(1'b0);
    @(negedge clk);
    chk("late_idle_gap", {31'b0, bus.busy}, 32'd0);
    @(negedge clk);
    chk("late_p1_enable", {31'b0, bus.mem_load_control & bus.gnt1}, 32'd1);
    wait_done(1'b1, d1);
    chk("late_done_spacing", d1 - d0, 32'd3);
    drop(1'b1);
    @(negedge clk);

    // Reset sampled at the edge that ends the ACCESS of a store.
    a = '{1'b0, 1'b1, 6'd7, 32'hA5A5_A5A5, 32'h0};
    @(negedge clk);
    set_port(a);
    sbq.push_back(a);
    @(negedge clk);
    chk("midrst_store_en", {31'b0, bus.mem_store_control}, 32'd1);
    n_reset = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    sbq.delete();
    exp_rd0 = '0;
    exp_rd1 = '0;
    drop(1'b0);
    chk("midrst_mem7", mem[7], 32'hA5A5_A5A5);
    chk("midrst_done0", {31'b0, bus.done0}, 32'd0);
    chk("midrst_gnt0", {31'b0, bus.gnt0}, 32'd0);
    chk("midrst_gnt1", {31'b0, bus.gnt1}, 32'd0);
    chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
    chk("midrst_store_en_off", {31'b0, bus.mem_store_control}, 32'd0);
    chk("midrst_rdata0", bus.rdata0, 32'd0);
    chk("midrst_rdata1", bus.rdata1, 32'd0);

    // First tie after that reset goes to port 0.
    a = '{1'b0, 1'b0, 6'd5, 32'h0, 32'hDEAD_BEEF};
    b = '{1'b1, 1'b0, 6'd0, 32'h0, 32'hCAFE_F00D};
    @(negedge clk);
    set_port(a);
    set_port(b);
    sbq.push_back(a);
    sbq.push_back(b);
    wait_any_done(d0, who);
    chk("post_rst_tie_owner", {31'b0, who}, 32'd0);
    drop(who);
    wait_any_done(d1, who);
    chk("post_rst_second_owner", {31'b0, who}, 32'd1);
    drop(who);
    repeat (2) @(negedge clk);
    chk("sb_drained", sbq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6, SHALL set the word-address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 n_reset  input  1  SHALL be the synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 req0, req1  input  1 each  SHALL be the access requests from the core 0 and core 1 caches.
REQ-006 we0, we1  input  1 each  SHALL select the access type: 1 = store word, 0 = load word.
REQ-007 addr0, addr1  input  ADDR_W each  SHALL be the word addresses.
REQ-008 wdata0, wdata1  input  DATA_W each  SHALL be the store data.
REQ-009 gnt0, gnt1  output  1 each  SHALL indicate that the port owns the memory.
REQ-010 done0, done1  output  1 each  SHALL be the single-cycle completion pulses.
REQ-011 rdata0, rdata1  output  DATA_W each  SHALL be the registered load results.
REQ-012 busy  output  1  SHALL be high whenever the FSM is not IDLE.
REQ-013 mem_address  output  ADDR_W  SHALL be the address to the data memory.
REQ-014 mem_wdata  output  DATA_W  SHALL be the write data to the data memory.
REQ-015 mem_load_control, mem_store_control  output  1 each  SHALL be the data memory read and write enables.
REQ-016 mem_rdata  input  DATA_W  SHALL be the asynchronous read data from the data memory.

Function
REQ-017 The FSM SHALL have three states, IDLE, ACCESS and RESP, with transitions IDLE->ACCESS when req0|req1, ACCESS->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-018 On the IDLE->ACCESS edge the block SHALL latch the winning port's we, addr and wdata into internal registers, plus an owner bit.
REQ-019 Arbitration SHALL work as follows: if only one request is present, that port wins; if both are present, the port not served most recently wins.
REQ-020 A last_served register SHALL update to the owner on entry to ACCESS.
REQ-021 In ACCESS, mem_address and mem_wdata SHALL equal the latched values, and mem_store_control SHALL equal latched we.
REQ-022 In ACCESS, mem_load_control SHALL equal the inverse of latched we; exactly one enable is high for exactly one cycle.
REQ-023 Outside ACCESS, mem_load_control and mem_store_control SHALL be 0, and mem_address and mem_wdata SHALL be 0.
REQ-024 For a load, on the ACCESS->RESP edge, mem_rdata SHALL be captured into rdata of the owner port.
REQ-025 The rdata of the non-owner port SHALL be unchanged.
REQ-026 A store SHALL leave both rdata registers unchanged.
REQ-027 gnt of the owner SHALL be high in ACCESS and RESP and low otherwise.
REQ-028 gnt0 and gnt1 SHALL never be high simultaneously.
REQ-029 done of the owner SHALL be high only in RESP, for exactly one cycle.
REQ-030 Fixed latency SHALL be: request sampled in IDLE at edge N, memory enable during cycle N+1, done during cycle N+2, and IDLE again at cycle N+3.
REQ-031 A requester SHALL hold req, we, addr and wdata stable until its done; the block SHALL ignore changes after latching.
REQ-032 req sampled during ACCESS or RESP SHALL NOT start a transaction; requests are only evaluated in IDLE.
REQ-033 A request still pending in IDLE SHALL be granted; a port whose req is still high in the RESP cycle after its own done SHALL be treated as a new request in IDLE.
REQ-034 Back-to-back contention SHALL alternate strictly: continuous req0 and req1 yields owners 0,1,0,1,... with one transaction per 3 cycles.
REQ-035 Address and data SHALL be passed unmodified with no arithmetic; the ADDR_W-bit address SHALL never be truncated or extended.

Reset
REQ-036 While n_reset is sampled low, the state SHALL become IDLE and last_served SHALL become 1, so port 0 wins the first tie.
REQ-037 While n_reset is sampled low, rdata0, rdata1, the latched address, data and we, and the owner bit SHALL all become 0.
REQ-038 After reset, all outputs SHALL be 0: gnt, done, busy and the mem_* enables.
REQ-039 If reset is sampled at the edge ending ACCESS, a store SHALL still be committed by the memory, because the enable was high during that cycle.
REQ-040 In that case, no done SHALL be issued and rdata SHALL NOT be updated.
REQ-041 If reset is sampled during RESP, the done pulse SHALL be truncated, but rdata already captured SHALL be cleared by reset.

Verification
REQ-042 Single load: memory word 5 = 0xDEADBEEF; req0=1, we0=0, addr0=5 -> mem_load_control=1 with mem_address=5 one cycle after sampling; done0 the next cycle; rdata0=0xDEADBEEF; gnt1 stays 0.
REQ-043 Store then load: req1 store addr 0x3F data 0x12345678, then req1 load addr 0x3F -> exactly one mem_store_control pulse; rdata1=0x12345678; rdata0 unchanged at 0.
REQ-044 Simultaneous requests after reset: req0 and req1 both high, held -> owners 0,1,0,1 across four transactions, done pulses 3 cycles apart, gnt never overlapping.
REQ-045 Late request: req1 raised during core 0's ACCESS -> req1 not served until IDLE; then granted with mem enable exactly 2 cycles after core 0's done.
REQ-046 Reset mid-operation: n_reset low for one edge during ACCESS of a store to addr 7 data 0xA5A5A5A5 -> memory word 7 = 0xA5A5A5A5; no done; all outputs 0 the next cycle; port 0 wins the next tie.
